// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HELD  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] inst;
   } ifid_t;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that returns while the stage is stalled.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_load,
   input  logic  i_clear,
   input  ifid_t i_dat,
   output ifid_t o_dat
);

   ifid_t r_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dat <= '{pc: 32'h0, pc_plus4: 32'h0, inst: INST_NOP};
      end else if (i_clear) begin
         r_dat <= '{pc: 32'h0, pc_plus4: 32'h0, inst: INST_NOP};
      end else if (i_load) begin
         r_dat <= i_dat;
      end
   end

   assign o_dat = r_dat;

endmodule

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: PC register, imem handshake, IF/ID register, stall/flush handling.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_plus4,
   output logic [31:0] ifid_inst,
   output logic        ifid_valid
);

   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   ifid_t        r_ifid, w_ifid_nxt;
   logic         r_ifid_valid, w_valid_nxt;
   logic         w_skid_load, w_skid_clear;
   ifid_t        w_skid;
   ifid_t        w_fetched;
   logic [31:0]  w_pc_plus4;
   logic         w_accept;

   assign w_pc_plus4 = r_pc + PC_STEP;
   assign w_accept   = imem_req & imem_ready;
   assign w_fetched  = '{pc: r_pc, pc_plus4: w_pc_plus4, inst: imem_rdata};

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_dat   (w_fetched),
      .o_dat   (w_skid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_ifid       <= '{pc: 32'h0, pc_plus4: 32'h0, inst: INST_NOP};
         r_ifid_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_ifid       <= w_ifid_nxt;
         r_ifid_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_ifid_nxt   = r_ifid;
      w_valid_nxt  = r_ifid_valid;
      w_skid_load  = 1'b0;
      w_skid_clear = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt = FETCH;
         end
         FETCH: begin
            if (flush) begin
               // Anything accepted this cycle belongs to the squashed path.
               w_ifid_nxt.inst = INST_NOP;
               w_valid_nxt     = 1'b0;
               w_pc_nxt        = align_pc(pc_in);
               w_skid_clear    = 1'b1;
            end else if (w_accept && !stall) begin
               w_ifid_nxt  = w_fetched;
               w_valid_nxt = 1'b1;
               w_pc_nxt    = align_pc(pc_in);
            end else if (w_accept) begin
               w_skid_load = 1'b1;
               w_state_nxt = HELD;
            end else if (!stall) begin
               w_ifid_nxt.inst = INST_NOP;
               w_valid_nxt     = 1'b0;
            end
         end
         HELD: begin
            if (flush) begin
               w_ifid_nxt.inst = INST_NOP;
               w_valid_nxt     = 1'b0;
               w_pc_nxt        = align_pc(pc_in);
               w_skid_clear    = 1'b1;
               w_state_nxt     = FETCH;
            end else if (!stall) begin
               w_ifid_nxt  = w_skid;
               w_valid_nxt = 1'b1;
               w_pc_nxt    = align_pc(pc_in);
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign imem_req      = (r_state == FETCH);
   assign imem_addr     = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign ifid_pc       = r_ifid.pc;
   assign ifid_pc_plus4 = r_ifid.pc_plus4;
   assign ifid_inst     = r_ifid.inst;
   assign ifid_valid    = r_ifid_valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit RISC-V pipeline. Holds the program counter, produces `pc_plus4` for the PC-select mux, and loads that mux's `pc_in` back as the next PC. Fetches from instruction memory over a ready/request handshake and fills the IF/ID pipeline register. Honours hazard-unit stall and branch/jump flush, and buffers an instruction that returns while stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_in`  in  32  next PC from PC-select mux: `pc_plus4` or ALU target.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  taken branch/jump: squash IF/ID, redirect to `pc_in`.
- `pc_plus4`  out  32  current PC + 4, combinational, to PC-select mux.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to current PC.
- `imem_ready`  in  1  `imem_rdata` valid for `imem_addr` this cycle.
- `imem_rdata`  in  32  instruction word.
- `ifid_pc`, `ifid_pc_plus4`, `ifid_inst`  out  32 each  IF/ID register contents.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

## Operation
- accept = `imem_req & imem_ready`. The memory has no outstanding-transaction state. Data always corresponds to `imem_addr` in the same cycle.
- `pc_plus4` = pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- PC load stores {`pc_in`[31:2], 2'b00}. Low bits are silently dropped.
- FSM states: IDLE, FETCH, HELD.
- IDLE
  - Entered on reset. `imem_req`=0.
  - Unconditionally goes to FETCH next cycle.
- FETCH (`imem_req`=1)
  - Accept & !stall: IF/ID <= {pc, pc+4, rdata, valid=1}; pc <= `pc_in`; stay in FETCH.
  - Accept & stall: rdata, pc and pc+4 go into the skid buffer; PC and IF/ID hold; go to HELD.
  - No accept & !stall: bubble into IF/ID (valid=0, inst=NOP 32'h0000_0013; pc fields hold); PC holds.
  - No accept & stall: everything holds.
- HELD (`imem_req`=0)
  - While stall: hold.
  - When stall drops: IF/ID <= skid contents with valid=1; pc <= `pc_in`; go to FETCH.
- Flush has the highest priority in every state except IDLE, and overrides stall.
  - Actions: ifid_valid <= 0, ifid_inst <= NOP, pc <= `pc_in`, skid discarded, go to FETCH.
  - Any instruction accepted in the flush cycle is discarded.
- Flush during IDLE is ignored.

## Timing
- Reset values:
  - pc = `RESET_PC`, state IDLE, `imem_req`=0.
  - `ifid_pc`=0, `ifid_pc_plus4`=0, `ifid_inst`=NOP, `ifid_valid`=0.
  - `imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
- First request occurs in the 2nd rising edge after `rst` deasserts, i.e. one IDLE cycle.
- Zero-wait memory: one instruction per cycle. Accept at edge N gives IF/ID valid after edge N, and `imem_addr` = new PC after edge N.
- `pc_plus4` and `imem_addr` change only after a PC load. `imem_req` is registered from state.
- Asserting `rst` mid-fetch clears everything immediately; the in-flight request is abandoned.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, FETCH, HELD};
  - `INST_NOP` = 32'h0000_0013;
  - `PC_STEP` = 4.
- Sub-module `fetch_skid_buf`: one-entry register holding {pc, pc_plus4, inst} with load/clear. Everything else lives in `fetch_stage`.

## Test plan
- Reset release with `imem_ready`=1, `pc_in` looped from `pc_plus4`:
  - IF/ID shows pc 0, 4, 8 on consecutive cycles;
  - first valid appears 2 cycles after reset release.
- `imem_ready` low for 3 cycles at pc 0x10:
  - PC holds at 0x10;
  - 3 bubbles (valid=0, inst=0x13);
  - then inst at 0x10 captured.
- Stall for 2 cycles coinciding with accept of 0x20 (rdata 0xDEADBEEF):
  - `imem_req` drops;
  - IF/ID holds;
  - after stall release IF/ID = {0x20, 0x24, 0xDEADBEEF}, next fetch at 0x24.
- Flush with `pc_in`=0x100 while stalled in HELD:
  - skid discarded;
  - ifid_valid=0;
  - next `imem_addr`=0x100.
- `pc_in`=0x0000_0207 on load: PC becomes 0x0000_0204.
- PC 0xFFFF_FFFC: `pc_plus4`=0, and the fetch after it is at 0.
